// File: rtl/snake_collision.sv
// Pixel-level apple/border drawing and per-frame collision latching for the snake game,
// with the IDLE/PLAY/OVER game FSM that grows the snake and relocates the apple.
module snake_collision #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int CELL      = 10,
  parameter int BORDER    = 10,
  parameter int SIZE_INIT = 4,
  parameter int SIZE_MAX  = 31
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic [9:0] xCount,
  input  logic [9:0] yCount,
  input  logic       snakeHead,
  input  logic       snakeBody,
  input  logic       play,
  output logic       start,
  output logic [4:0] size,
  output logic       apple,
  output logic       border,
  output logic       game_over,
  output logic [7:0] score
);

  localparam logic [9:0]  L_HA   = 10'(H_ACTIVE);
  localparam logic [9:0]  L_VA   = 10'(V_ACTIVE);
  localparam logic [9:0]  L_HB   = 10'(H_ACTIVE - BORDER);
  localparam logic [9:0]  L_VB   = 10'(V_ACTIVE - BORDER);
  localparam logic [9:0]  L_BRD  = 10'(BORDER);
  localparam logic [9:0]  L_CELL = 10'(CELL);
  localparam logic [9:0]  L_AX0  = 10'(H_ACTIVE / 2);
  localparam logic [9:0]  L_AY0  = 10'(V_ACTIVE / 2);
  localparam logic [4:0]  L_SZI  = 5'(SIZE_INIT);
  localparam logic [4:0]  L_SZM  = 5'(SIZE_MAX);
  localparam logic [15:0] L_SEED = 16'hACE1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t      r_state;
  logic [9:0]  r_xd, r_yd;
  logic        r_play_s1, r_play_s2;
  logic [15:0] r_lfsr;
  logic [9:0]  r_apple_x, r_apple_y;
  logic        r_hit_apple, r_hit_self, r_hit_wall;

  logic        w_apple, w_border, w_frame_end, w_fb;
  logic [5:0]  w_col_raw, w_row_raw, w_col, w_row;
  logic [9:0]  w_new_x, w_new_y;

  assign w_apple = (r_xd > r_apple_x) && (r_xd < r_apple_x + L_CELL) &&
                   (r_yd > r_apple_y) && (r_yd < r_apple_y + L_CELL);

  assign w_border = (r_xd < L_HA) && (r_yd < L_VA) &&
                    ((r_xd < L_BRD) || (r_xd >= L_HB) || (r_yd < L_BRD) || (r_yd >= L_VB));

  assign w_frame_end = (xCount == 10'd0) && (yCount == L_VA);

  // Taps 16,14,13,11 in a right-shifting Fibonacci arrangement
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Clamp the random cell so the apple never lands on the wall
  assign w_col_raw = r_lfsr[5:0];
  assign w_row_raw = r_lfsr[13:8];
  assign w_col = (w_col_raw == 6'd0)  ? 6'd1  :
                 (w_col_raw == 6'd63) ? 6'd62 : w_col_raw;
  assign w_row = (w_row_raw == 6'd0)  ? 6'd1  :
                 (w_row_raw > 6'd46)  ? w_row_raw - 6'd32 : w_row_raw;
  assign w_new_x = {4'd0, w_col} * L_CELL;
  assign w_new_y = {4'd0, w_row} * L_CELL;

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      r_xd      <= '0;
      r_yd      <= '0;
      apple     <= 1'b0;
      border    <= 1'b0;
      r_play_s1 <= 1'b0;
      r_play_s2 <= 1'b0;
      r_lfsr    <= L_SEED;
    end else begin
      r_xd      <= xCount;
      r_yd      <= yCount;
      apple     <= w_apple;
      border    <= w_border;
      r_play_s1 <= play;
      r_play_s2 <= r_play_s1;
      r_lfsr    <= {w_fb, r_lfsr[15:1]};
    end
  end

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      start       <= 1'b0;
      game_over   <= 1'b0;
      size        <= L_SZI;
      score       <= '0;
      r_apple_x   <= L_AX0;
      r_apple_y   <= L_AY0;
      r_hit_apple <= 1'b0;
      r_hit_self  <= 1'b0;
      r_hit_wall  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          start       <= 1'b0;
          game_over   <= 1'b0;
          size        <= L_SZI;
          score       <= '0;
          r_apple_x   <= L_AX0;
          r_apple_y   <= L_AY0;
          r_hit_apple <= 1'b0;
          r_hit_self  <= 1'b0;
          r_hit_wall  <= 1'b0;
          if (r_play_s2) begin
            r_state <= S_PLAY;
            start   <= 1'b1;
          end
        end
        S_PLAY: begin
          if (!r_play_s2) begin
            r_state     <= S_IDLE;
            start       <= 1'b0;
            size        <= L_SZI;
            score       <= '0;
            r_apple_x   <= L_AX0;
            r_apple_y   <= L_AY0;
            r_hit_apple <= 1'b0;
            r_hit_self  <= 1'b0;
            r_hit_wall  <= 1'b0;
          end else if (w_frame_end) begin
            r_hit_apple <= 1'b0;
            r_hit_self  <= 1'b0;
            r_hit_wall  <= 1'b0;
            // A fatal hit outranks an apple eaten in the same frame
            if (r_hit_self || r_hit_wall) begin
              r_state   <= S_OVER;
              start     <= 1'b0;
              game_over <= 1'b1;
            end else if (r_hit_apple) begin
              size      <= (size < L_SZM) ? size + 5'd1 : size;
              score     <= (score != 8'hFF) ? score + 8'd1 : score;
              r_apple_x <= w_new_x;
              r_apple_y <= w_new_y;
            end
          end else begin
            r_hit_apple <= r_hit_apple | (snakeHead & w_apple);
            r_hit_self  <= r_hit_self  | (snakeHead & snakeBody);
            r_hit_wall  <= r_hit_wall  | (snakeHead & w_border);
          end
        end
        S_OVER: begin
          if (!r_play_s2) begin
            r_state   <= S_IDLE;
            game_over <= 1'b0;
            size      <= L_SZI;
            score     <= '0;
            r_apple_x <= L_AX0;
            r_apple_y <= L_AY0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_collision.sv
// Directed plus randomized bench for snake_collision with a frame-level game model.
module tb_snake_collision;

  logic       VGA_clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] xCount = 10'd700, yCount = 10'd500;
  logic       snakeHead = 1'b0, snakeBody = 1'b0, play = 1'b0;
  logic       start, apple, border, game_over;
  logic [4:0] size;
  logic [7:0] score;

  snake_collision dut (
    .VGA_clk(VGA_clk), .reset(reset), .xCount(xCount), .yCount(yCount),
    .snakeHead(snakeHead), .snakeBody(snakeBody), .play(play),
    .start(start), .size(size), .apple(apple), .border(border),
    .game_over(game_over), .score(score)
  );

  always #5 VGA_clk = ~VGA_clk;

  int total = 0;
  int bad = 0;

  // Game model: 0 idle, 1 play, 2 over
  int m_state, m_size, m_score, m_ax, m_ay;
  bit h_apple, h_self, h_wall;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int taps[4] = '{16, 14, 13, 11};
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 4; i++) fb ^= s[16 - taps[i]];
    return {fb, s[15:1]};
  endfunction

  always @(posedge VGA_clk or posedge reset)
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_next(m_lfsr);

  function automatic bit is_apple(input int x, input int y);
    return x > m_ax && x < m_ax + 10 && y > m_ay && y < m_ay + 10;
  endfunction

  function automatic bit is_border(input int x, input int y);
    return x < 640 && y < 480 && (x < 10 || x >= 630 || y < 10 || y >= 470);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    check({tag, ".start"}, start, (m_state == 1));
    check({tag, ".game_over"}, game_over, (m_state == 2));
    check({tag, ".size"}, size, m_size);
    check({tag, ".score"}, score, m_score);
  endtask

  task automatic model_idle();
    m_state = 0; m_size = 4; m_score = 0; m_ax = 320; m_ay = 240;
    h_apple = 0; h_self = 0; h_wall = 0;
  endtask

  // Present a pixel, then the head/body flags one cycle later, then check apple/border
  task automatic pix(input int x, input int y, input bit h, input bit b);
    @(negedge VGA_clk);
    xCount = 10'(x); yCount = 10'(y); snakeHead = 1'b0; snakeBody = 1'b0;
    @(negedge VGA_clk);
    xCount = 10'd700; yCount = 10'd500; snakeHead = h; snakeBody = b;
    if (m_state == 1 && h) begin
      if (is_apple(x, y))  h_apple = 1;
      if (b)               h_self  = 1;
      if (is_border(x, y)) h_wall  = 1;
    end
    @(negedge VGA_clk);
    snakeHead = 1'b0; snakeBody = 1'b0;
    check("apple_pix", apple, is_apple(x, y));
    check("border_pix", border, is_border(x, y));
  endtask

  task automatic frame();
    int col, row;
    @(negedge VGA_clk);
    xCount = 10'd0; yCount = 10'd480;
    if (m_state == 1) begin
      if (h_self || h_wall) m_state = 2;
      else if (h_apple) begin
        if (m_size < 31)  m_size++;
        if (m_score < 255) m_score++;
        col = int'(m_lfsr[5:0]);
        row = int'(m_lfsr[13:8]);
        if (col == 0) col = 1; else if (col == 63) col = 62;
        if (row == 0) row = 1; else if (row > 46) row -= 32;
        m_ax = col * 10; m_ay = row * 10;
      end
    end
    h_apple = 0; h_self = 0; h_wall = 0;
    @(negedge VGA_clk);
    xCount = 10'd700; yCount = 10'd500;
    chk_state("frame");
  endtask

  task automatic set_play(input bit v);
    @(negedge VGA_clk);
    play = v;
    repeat (3) @(negedge VGA_clk);
    if (v && m_state == 0) begin
      m_state = 1; h_apple = 0; h_self = 0; h_wall = 0;
    end else if (!v && m_state != 0) model_idle();
    chk_state("play");
  endtask

  initial begin
    int r;
    model_idle();
    repeat (2) @(negedge VGA_clk);
    chk_state("reset");
    check("reset.apple", apple, 0);
    check("reset.border", border, 0);
    reset = 1'b0;

    // Start, then the default apple at (320,240)
    set_play(1);
    pix(325, 245, 0, 0);
    pix(320, 245, 0, 0);
    pix(329, 249, 0, 0);
    pix(330, 245, 0, 0);
    pix(639, 479, 0, 0);
    pix(640, 5, 0, 0);

    // Eat the apple, probe the relocated one
    pix(325, 245, 1, 0);
    frame();
    check("apple_x", dut.r_apple_x, m_ax);
    check("apple_y", dut.r_apple_y, m_ay);
    check("col_ok", (m_ax >= 10 && m_ax <= 620), 1);
    check("row_ok", (m_ay >= 10 && m_ay <= 460), 1);
    pix(m_ax + 5, m_ay + 5, 0, 0);

    // Wall and apple in one frame: the wall wins
    pix(5, 100, 1, 0);
    pix(m_ax + 5, m_ay + 5, 1, 0);
    frame();
    set_play(0);
    set_play(1);

    // Self hit, then back to idle
    pix(200, 200, 1, 1);
    frame();
    set_play(0);
    set_play(1);

    // Size saturation, then score saturation
    repeat (28) begin
      pix(m_ax + 5, m_ay + 5, 1, 0);
      frame();
    end
    check("sat.size", size, 31);
    check("sat.score", score, 28);
    repeat (230) begin
      pix(m_ax + 1 + int'($urandom_range(0, 8)), m_ay + 1 + int'($urandom_range(0, 8)), 1, 0);
      frame();
    end
    check("sat.score255", score, 255);

    // Reset with a wall hit latched
    pix(5, 100, 1, 0);
    @(negedge VGA_clk);
    xCount = 10'd5; yCount = 10'd100;
    repeat (2) @(negedge VGA_clk);
    check("pre_rst.border", border, 1);
    reset = 1'b1;
    #1;
    model_idle();
    chk_state("mid_rst");
    check("mid_rst.border", border, 0);
    check("mid_rst.apple", apple, 0);
    @(negedge VGA_clk);
    xCount = 10'd700; yCount = 10'd500; reset = 1'b0;
    set_play(1);
    frame();

    // Randomized frames
    repeat (60) begin
      if (m_state == 2) begin set_play(0); set_play(1); end
      else if (m_state == 0) set_play(1);
      else if ($urandom_range(0, 9) == 0) begin set_play(0); set_play(1); end
      repeat ($urandom_range(1, 3)) begin
        r = int'($urandom_range(0, 9));
        if (r < 5)
          pix(m_ax + int'($urandom_range(0, 10)), m_ay + int'($urandom_range(0, 10)), 1, 0);
        else if (r < 8)
          pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else if (r == 8)
          pix(int'($urandom_range(100, 500)), int'($urandom_range(100, 400)), 1, 1);
        else
          pix(int'($urandom_range(0, 9)), int'($urandom_range(0, 479)), 1, 0);
      end
      frame();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
